// File: rtl/jukebox_pkg.sv
// Shared types and defaults for the jukebox playback path.
// The pacer FSM encoding is exported so benches and checkers can decode it.
package jukebox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } pacer_state_t;

    localparam logic [22:0] SONG_START_DEF = 23'h000000;
    localparam logic [22:0] SONG_END_DEF   = 23'h07FFFF;

endpackage

// File: rtl/playback_pacer_if.sv
// Song-memory read port between the pacer (master) and song memory (slave).
// Handshake: mem_req rises with mem_addr stable and stays high until mem_ack; mem_ack is a one-cycle strobe, meaningful only while mem_req=1, with mem_data valid in that cycle.
interface playback_pacer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/playback_pacer_tick_divider.sv
// Sample-period divider: latches a floored divisor and emits one tick every div_eff running clocks.
// The divisor is re-latched only at reset release and on each tick, so a new div_in applies from the next period.
module tick_divider #(
    parameter int unsigned MIN_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div_in,
    input  logic        play_en,
    input  logic        clr,
    output logic        tick
);
    logic [31:0] div_q;
    logic [31:0] count;
    logic [31:0] div_eff;
    logic        load_pend;

    assign div_eff = (div_in < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div_in;
    // clr (restart) outranks a coinciding tick so no sample is emitted.
    assign tick    = play_en && !clr && (count == div_q - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 32'd0;
            div_q     <= 32'(MIN_DIV);
            load_pend <= 1'b1;
        end else begin
            load_pend <= 1'b0;
            if (load_pend || tick) begin
                div_q <= div_eff;
            end
            if (clr || tick) begin
                count <= 32'd0;
            end else if (play_en) begin
                count <= count + 32'd1;
            end
        end
    end
endmodule

// File: rtl/playback_pacer.sv
// Paces audio samples at one per divider period and prefetches the next sample from song memory between ticks.
// Walks the song address forward or backward with wrap, handles pause, restart and sticky underrun.
module playback_pacer
    import jukebox_pkg::*;
#(
    parameter int              ADDR_W     = 23,
    parameter int              DATA_W     = 16,
    parameter logic [ADDR_W-1:0] SONG_START = SONG_START_DEF,
    parameter logic [ADDR_W-1:0] SONG_END   = SONG_END_DEF,
    parameter int unsigned     MIN_DIV    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        div_in,
    input  logic               play_en,
    input  logic               dir_rev,
    input  logic               restart,
    playback_pacer_if.master   mem,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    output logic               underrun,
    output pacer_state_t       fsm_state
);
    pacer_state_t      state_q, state_n;
    logic              req_q, req_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              pend_q, pend_n;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_n;
    logic [DATA_W-1:0] pref_q, pref_n;
    logic [DATA_W-1:0] samp_q, samp_n;
    logic              sv_q, sv_n;
    logic              und_q, und_n;
    logic              tick;
    logic              ack;
    logic [ADDR_W-1:0] restart_addr;

    tick_divider #(.MIN_DIV(MIN_DIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .div_in  (div_in),
        .play_en (play_en),
        .clr     (restart),
        .tick    (tick)
    );

    assign ack          = mem.mem_ack && req_q;
    assign restart_addr = dir_rev ? SONG_END : SONG_START;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic rev);
        if (rev) begin
            return (a == SONG_START) ? SONG_END : a - ADDR_W'(1);
        end
        return (a == SONG_END) ? SONG_START : a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_n     = state_q;
        req_n       = req_q;
        addr_n      = addr_q;
        pend_n      = pend_q;
        pend_addr_n = pend_addr_q;
        pref_n      = pref_q;
        samp_n      = samp_q;
        sv_n        = 1'b0;
        und_n       = restart ? 1'b0 : und_q;
        case (state_q)
            IDLE: begin
                if (restart) addr_n = restart_addr;
                state_n = REQ;
            end
            REQ: begin
                req_n   = 1'b1;
                state_n = WAIT;
                if (restart) begin
                    pend_n      = 1'b1;
                    pend_addr_n = restart_addr;
                end else if (tick) begin
                    und_n = 1'b1;
                    sv_n  = 1'b1;
                end
            end
            WAIT: begin
                if (restart) begin
                    if (ack) begin
                        // Restart coincides with completion: drop the data and refetch at once.
                        req_n   = 1'b0;
                        pend_n  = 1'b0;
                        addr_n  = restart_addr;
                        state_n = REQ;
                    end else begin
                        pend_n      = 1'b1;
                        pend_addr_n = restart_addr;
                    end
                end else begin
                    if (tick) begin
                        und_n = 1'b1;
                        sv_n  = 1'b1;
                    end
                    if (ack) begin
                        req_n = 1'b0;
                        if (pend_q) begin
                            pend_n  = 1'b0;
                            addr_n  = pend_addr_q;
                            state_n = REQ;
                        end else begin
                            pref_n  = mem.mem_data;
                            state_n = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (restart) begin
                    addr_n  = restart_addr;
                    pref_n  = '0;
                    state_n = REQ;
                end else if (tick) begin
                    samp_n  = pref_q;
                    sv_n    = 1'b1;
                    addr_n  = step_addr(addr_q, dir_rev);
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= SONG_START;
            pend_q      <= 1'b0;
            pend_addr_q <= SONG_START;
            pref_q      <= '0;
            samp_q      <= '0;
            sv_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            req_q       <= req_n;
            addr_q      <= addr_n;
            pend_q      <= pend_n;
            pend_addr_q <= pend_addr_n;
            pref_q      <= pref_n;
            samp_q      <= samp_n;
            sv_q        <= sv_n;
            und_q       <= und_n;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;
    assign sample_out    = samp_q;
    assign sample_valid  = sv_q;
    assign underrun      = und_q;
    assign fsm_state     = state_q;
endmodule

// File: tb/tb_playback_pacer.sv
// Directed bench for playback_pacer: a table of divisor/latency vectors plus hand sequences for
// reset, ordering, pause, divisor change, underrun, mid-fetch restart and address wrap.
module tb_playback_pacer;
  import jukebox_pkg::*;

  localparam int AW = 23;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] div_a, div_b;
  logic play_a, dir_a, restart_a, play_b, dir_b, restart_b;
  logic [DW-1:0] samp_a, samp_b;
  logic sv_a, sv_b, und_a, und_b;
  pacer_state_t st_a, st_b;

  playback_pacer_if #(.ADDR_W(AW), .DATA_W(DW)) mif_a ();
  playback_pacer_if #(.ADDR_W(AW), .DATA_W(DW)) mif_b ();

  playback_pacer #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst(rst), .div_in(div_a), .play_en(play_a), .dir_rev(dir_a),
    .restart(restart_a), .mem(mif_a.master), .sample_out(samp_a),
    .sample_valid(sv_a), .underrun(und_a), .fsm_state(st_a)
  );

  playback_pacer #(.ADDR_W(AW), .DATA_W(DW), .SONG_END(23'd3)) dut_b (
    .clk(clk), .rst(rst), .div_in(div_b), .play_en(play_b), .dir_rev(dir_b),
    .restart(restart_b), .mem(mif_b.master), .sample_out(samp_b),
    .sample_valid(sv_b), .underrun(und_b), .fsm_state(st_b)
  );

  function automatic logic [15:0] mem_val(input logic [AW-1:0] a);
    return 16'hC000 | {4'h0, a[11:0]};
  endfunction

  // Song memory models: ack arrives lat cycles after mem_req is first seen high.
  int lat_a = 2;
  int cnt_a = 0;
  int cnt_b = 0;
  int ack_cnt_a = 0;
  initial begin
    mif_a.mem_ack = 1'b0; mif_a.mem_data = '0;
    mif_b.mem_ack = 1'b0; mif_b.mem_data = '0;
  end
  always @(negedge clk) begin
    mif_a.mem_ack = 1'b0;
    if (!rst && mif_a.mem_req) begin
      cnt_a++;
      if (cnt_a >= lat_a) begin
        mif_a.mem_ack  = 1'b1;
        mif_a.mem_data = mem_val(mif_a.mem_addr);
        ack_cnt_a++;
      end
    end else cnt_a = 0;
  end
  always @(negedge clk) begin
    mif_b.mem_ack = 1'b0;
    if (!rst && mif_b.mem_req) begin
      cnt_b++;
      if (cnt_b >= 2) begin
        mif_b.mem_ack  = 1'b1;
        mif_b.mem_data = mem_val(mif_b.mem_addr);
      end
    end else cnt_b = 0;
  end

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_sv(input int sel, input string name, output int t, output logic [15:0] d);
    t = -1;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((sel == 0) ? sv_a : sv_b) begin
        t = cyc;
        d = (sel == 0) ? samp_a : samp_b;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: no sample_valid within 200 cycles", name);
  endtask

  task automatic wait_state_a(input pacer_state_t s, input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (st_a == s) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: state %0d not reached, stuck at %0d", name, s, st_a);
  endtask

  // Called at a negedge; the pulse is sampled by the very next rising edge.
  task automatic pulse_restart_a();
    restart_a = 1'b1;
    @(negedge clk);
    restart_a = 1'b0;
  endtask

  typedef struct {
    logic [31:0] div;
    int          lat;
    int          period;
    logic        under;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int t0, t1, t2, n;
    logic [15:0] d;

    vecs[0] = '{32'd10, 2, 10, 1'b0};
    vecs[1] = '{32'd5,  3, 5,  1'b0};
    vecs[2] = '{32'd5,  4, 5,  1'b1};
    vecs[3] = '{32'd4,  2, 4,  1'b0};
    vecs[4] = '{32'd0,  1, 2,  1'b1};
    vecs[5] = '{32'd1,  1, 2,  1'b1};

    div_a = 32'd10; play_a = 1'b1; dir_a = 1'b0; restart_a = 1'b0;
    div_b = 32'd10; play_b = 1'b0; dir_b = 1'b0; restart_b = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(mif_a.mem_req),  32'd0);
    check("rst_addr",  32'(mif_a.mem_addr), 32'd0);
    check("rst_samp",  32'(samp_a),         32'd0);
    check("rst_sv",    32'(sv_a),           32'd0);
    check("rst_und",   32'(und_a),          32'd0);
    check("rst_state", 32'(st_a),           32'(IDLE));
    check("rst_state_b", 32'(st_b),         32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle_to_req", 32'(st_a), 32'(REQ));

    // Period 10, sequential addresses, data per address
    wait_sv(0, "seq0", t0, d);
    check("seq_data0", 32'(d), 32'(mem_val(23'd0)));
    for (int i = 1; i < 4; i++) begin
      wait_sv(0, "seq", t1, d);
      check("seq_data", 32'(d), 32'(mem_val(AW'(i))));
      check("seq_period", 32'(t1 - t0), 32'd10);
      t0 = t1;
    end

    // Pause: no samples, outstanding fetch completes exactly once
    play_a = 1'b0;
    n = 0;
    t0 = ack_cnt_a;
    repeat (50) begin
      @(negedge clk);
      if (sv_a) n++;
    end
    check("pause_no_sv", 32'(n), 32'd0);
    check("pause_acks", 32'(ack_cnt_a - t0), 32'd1);
    check("pause_hold", 32'(st_a), 32'(HOLD));
    play_a = 1'b1;

    // Divisor change mid-period applies from the following period
    div_a = 32'd8;
    wait_sv(0, "div_w1", t0, d);
    wait_sv(0, "div_w2", t0, d);
    wait_sv(0, "div_t0", t0, d);
    repeat (3) @(negedge clk);
    div_a = 32'd20;
    wait_sv(0, "div_t1", t1, d);
    wait_sv(0, "div_t2", t2, d);
    check("div_cur_period", 32'(t1 - t0), 32'd8);
    check("div_next_period", 32'(t2 - t1), 32'd20);

    // Table: divisor floor, latency boundary, underrun flag
    for (int i = 0; i < 6; i++) begin
      div_a = vecs[i].div;
      lat_a = vecs[i].lat;
      wait_sv(0, "vec_latch", t0, d);
      wait_state_a(HOLD, "vec_hold");
      pulse_restart_a();
      wait_sv(0, "vec_p0", t0, d);
      if (!vecs[i].under) check("vec_first", 32'(d), 32'(mem_val(23'd0)));
      wait_sv(0, "vec_p1", t1, d);
      wait_sv(0, "vec_p2", t2, d);
      check("vec_period", 32'(t2 - t1), 32'(vecs[i].period));
      check("vec_underrun", 32'(und_a), 32'(vecs[i].under));
    end

    // Underrun: repeated samples flagged, no address skipped, restart clears
    div_a = 32'd10;
    lat_a = 2;
    wait_sv(0, "ur_latch", t0, d);
    wait_state_a(HOLD, "ur_hold");
    pulse_restart_a();
    div_a = 32'd4;
    lat_a = 7;
    for (int k = 0; k < 3; k++) exp_q.push_back(mem_val(23'd0));
    for (int k = 0; k < 3; k++) exp_q.push_back(mem_val(23'd1));
    exp_q.push_back(mem_val(23'd2));
    while (exp_q.size() > 0) begin
      wait_sv(0, "ur_pulse", t0, d);
      check("ur_sample", 32'(d), 32'(exp_q.pop_front()));
    end
    check("ur_flag", 32'(und_a), 32'd1);
    pulse_restart_a();
    check("ur_cleared", 32'(und_a), 32'd0);

    // Restart while WAIT at address 5: request held, data dropped, refetch from start
    div_a = 32'd10;
    lat_a = 2;
    wait_sv(0, "rs_latch1", t0, d);
    wait_sv(0, "rs_latch2", t0, d);
    wait_state_a(HOLD, "rs_hold");
    pulse_restart_a();
    for (int i = 0; i < 5; i++) begin
      wait_sv(0, "rs_walk", t0, d);
      check("rs_walk", 32'(d), 32'(mem_val(AW'(i))));
    end
    lat_a = 6;
    wait_state_a(WAIT, "rs_wait");
    check("rs_addr5", 32'(mif_a.mem_addr), 32'd5);
    pulse_restart_a();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mif_a.mem_req) break;
      n++;
      @(negedge clk);
    end
    check("rs_req_held", 32'(n), 32'd5);
    lat_a = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif_a.mem_req) break;
    end
    check("rs_req_again", 32'(mif_a.mem_req), 32'd1);
    check("rs_new_addr", 32'(mif_a.mem_addr), 32'd0);
    wait_sv(0, "rs_first", t0, d);
    check("rs_no_stale", 32'(d), 32'(mem_val(23'd0)));
    check("rs_no_underrun", 32'(und_a), 32'd0);

    // Wrap-around on a 4-entry song, forward then reverse
    play_b = 1'b1;
    exp_q.push_back(mem_val(23'd0));
    exp_q.push_back(mem_val(23'd1));
    exp_q.push_back(mem_val(23'd2));
    exp_q.push_back(mem_val(23'd3));
    exp_q.push_back(mem_val(23'd0));
    while (exp_q.size() > 0) begin
      wait_sv(1, "wrap_fwd", t0, d);
      check("wrap_fwd", 32'(d), 32'(exp_q.pop_front()));
    end
    dir_b = 1'b1;
    exp_q.push_back(mem_val(23'd1));
    exp_q.push_back(mem_val(23'd0));
    exp_q.push_back(mem_val(23'd3));
    exp_q.push_back(mem_val(23'd2));
    while (exp_q.size() > 0) begin
      wait_sv(1, "wrap_rev", t0, d);
      check("wrap_rev", 32'(d), 32'(exp_q.pop_front()));
    end
    check("wrap_no_underrun", 32'(und_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end
endmodule
